stream_mux_nch: RTL and testbench
=================================

Name: stream_mux_nch

Overview:
- Parametrised N-channel successor to the two-input stream mux.
- Merges NCH ready-less input streams into one AXI-Stream output, in a single clock domain.
- Each channel has its own first-word-fallthrough FIFO and a per-channel arbitration-suppress input.
- Round-robin arbitration per word or per packet (TLAST), selected by parameter. The output carries the source channel index. Sits between the FOFB link receivers and the readout consumer.

Parameters:
- NCH, 4, number of input channels (2..16).
- DW, 9, data width per word (TUSER folded in by the caller).
- AW, 4, FIFO address width; depth per channel is 2**AW words.
- PACKET_MODE, 0, 0 = arbitrate per word; 1 = hold the grant until the word with TLAST is transferred.
- CW, $clog2(NCH), channel-index width (derived, not overridden).

Ports:
- aclk  in  1  single clock for all logic.
- areset  in  1  asynchronous, active-high reset.
- s_tvalid  in  NCH  per-channel word strobe; no back-pressure on inputs.
- s_tdata  in  NCH*DW  channel k occupies bits [k*DW +: DW].
- s_tlast  in  NCH  per-channel end-of-packet; ignored when PACKET_MODE=0.
- s_arb_req_suppress  in  NCH  1 = channel is not eligible for a new grant.
- m_tvalid  out  1  output word valid.
- m_tready  in  1  output accept.
- m_tdata  out  DW  output word.
- m_tlast  out  1  stored TLAST of the output word; 0 when PACKET_MODE=0.
- m_tid  out  CW  channel index of the output word.
- ovf  out  NCH  sticky per-channel overflow flag.
- ovf_clr  in  NCH  1-cycle pulse clears the matching ovf bit.
- drop_cnt  out  NCH*16  per-channel drop counters; see Optional Feature.

Behaviour:
Reset (areset=1, takes effect immediately):
- All FIFOs are emptied.
- State is IDLE and the rr pointer is 0.
- m_tvalid=0, m_tdata=0, m_tlast=0, m_tid=0.
- ovf=0 and drop_cnt=0.
- Reset asserted mid-packet discards all buffered data. No partial word appears after release.

FIFO write:
- A word is written when s_tvalid[k]=1 and count[k] < 2**AW.
- If count[k] = 2**AW, the word is dropped and ovf[k] is set.
- If a drop and ovf_clr[k] occur in the same cycle, the set wins.
- A simultaneous read and write on a full FIFO writes nothing: the full check uses the registered count.
- Count stays in range 0..2**AW. Pointers wrap modulo 2**AW.

Eligibility and selection:
- Channel k is eligible when count[k] != 0 and s_arb_req_suppress[k] = 0.
- Round-robin search starts at rr+1 and wraps NCH-1 -> 0.

State machine:
- IDLE: if any channel is eligible, register grant=g and rr=g, then go to GRANT. m_tvalid=0 in IDLE.
- GRANT: m_tvalid = (count[grant] != 0). m_tdata, m_tlast and m_tid come combinationally from the head of FIFO[grant].
- Handshake is m_tvalid & m_tready. It pops one word from FIFO[grant].
- While m_tvalid=1 and m_tready=0, m_tdata, m_tlast and m_tid must remain stable.

Grant release, PACKET_MODE=0 (after each handshake):
- If another channel is eligible, grant the next one by round robin. This costs one bubble cycle through IDLE.
- Else, if the same channel is still non-empty, keep the grant with no bubble.
- Else go to IDLE.

Grant release, PACKET_MODE=1:
- The grant is held until a handshake with m_tlast=1, then release as in word mode.
- If the FIFO empties mid-packet, m_tvalid=0 and the grant is held; no other channel may interleave.
- Suppress affects only new grants. Asserting it mid-packet does not break the lock.

Latency and throughput:
- A word written into an empty FIFO with the mux in IDLE reaches m_tvalid at minimum 2 cycles later: 1 cycle FIFO, 1 cycle grant.
- Sustained rate is 1 word/cycle per held grant.

Overflow in packet mode:
- A drop mid-packet does not insert TLAST.
- The partial packet merges with the next packet's words.
- ovf flags the event; packet integrity is not guaranteed after an overflow.

Optional Feature:
STREAM_MUX_DROP_CNT_EN
- Defined: each channel has a 16-bit counter that increments on every dropped word and saturates at 16'hFFFF. ovf_clr[k] also zeroes counter k; if a drop coincides with the clear, the counter loads 1.
- Undefined: no counter logic is built and drop_cnt is tied to 0. The port list is identical in both builds.

Test Plan:
1. NCH=4, PACKET_MODE=0, m_tready=1; one word each into ch0..ch3 (data 0x10..0x13) in the same cycle -> outputs 0x11,0x12,0x13,0x10 with m_tid 1,2,3,0 (rr starts at 1 after reset), one bubble between words.
2. Ch2 only, 8 back-to-back words 0x00..0x07 -> first m_tvalid 2 cycles after the first write, then 8 consecutive cycles of m_tvalid, m_tid=2.
3. PACKET_MODE=1; ch0 sends a 3-word packet with a 2-cycle s_tvalid gap while ch1 holds a full packet -> ch0 words output contiguously with m_tid=0; m_tvalid drops during the gap; ch1 starts only after ch0 TLAST handshake.
4. AW=2, m_tready=0, 6 words into ch1 -> 4 stored, ovf[1]=1, drop_cnt[1]=2 (macro on) or 0 (macro off); ovf_clr[1] pulse -> ovf[1]=0.
5. s_arb_req_suppress[0]=1 with ch0 and ch3 non-empty -> only ch3 served; deassert suppress -> ch0 served next.
6. areset pulsed while m_tvalid=1 with m_tready=0 mid-packet -> m_tvalid=0 immediately, all counts 0, no stale word after release.

Source files
------------

// File: rtl/stream_mux_nch.sv
// N-channel ready-less stream merger: per-channel FWFT FIFO, round-robin grant per word or packet.
// Optional macro STREAM_MUX_DROP_CNT_EN adds saturating 16-bit per-channel drop counters.
module stream_mux_nch_fifo #(
  parameter int DW = 9,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wr,
  input  logic [DW:0]   i_wdata,
  input  logic          i_rd,
  input  logic          i_ovf_clr,
  output logic [DW:0]   o_head,
  output logic [AW:0]   o_cnt,
  output logic [AW:0]   o_cnt_nxt,
  output logic          o_ovf,
  output logic [15:0]   o_drop_cnt
);
  localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

  logic [DW:0]   r_mem [2**AW];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          r_ovf;
  logic          w_wr, w_rd, w_drop;

  // Full test uses the registered count, so a pop cannot make room in the same cycle.
  assign w_wr      = i_wr & (r_cnt != DEPTH);
  assign w_drop    = i_wr & (r_cnt == DEPTH);
  assign w_rd      = i_rd & (r_cnt != '0);
  assign o_cnt_nxt = r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
  assign o_cnt     = r_cnt;
  assign o_head    = r_mem[r_rp];
  assign o_ovf     = r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      r_cnt <= o_cnt_nxt;
      if (w_drop)         r_ovf <= 1'b1;
      else if (i_ovf_clr) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= i_wdata;
  end

`ifdef STREAM_MUX_DROP_CNT_EN
  logic [15:0] r_drop_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              r_drop_cnt <= '0;
    else if (i_ovf_clr)                   r_drop_cnt <= {15'd0, w_drop};
    else if (w_drop && r_drop_cnt != '1)  r_drop_cnt <= r_drop_cnt + 16'd1;
  end
  assign o_drop_cnt = r_drop_cnt;
`else
  assign o_drop_cnt = '0;
`endif
endmodule

module stream_mux_nch #(
  parameter  int NCH         = 4,
  parameter  int DW          = 9,
  parameter  int AW          = 4,
  parameter  int PACKET_MODE = 0,
  localparam int CW          = $clog2(NCH)
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [NCH-1:0]    s_tvalid,
  input  logic [NCH*DW-1:0] s_tdata,
  input  logic [NCH-1:0]    s_tlast,
  input  logic [NCH-1:0]    s_arb_req_suppress,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DW-1:0]     m_tdata,
  output logic              m_tlast,
  output logic [CW-1:0]     m_tid,
  output logic [NCH-1:0]    ovf,
  input  logic [NCH-1:0]    ovf_clr,
  output logic [NCH*16-1:0] drop_cnt
);
  typedef enum logic {IDLE, GRANT} state_t;

  state_t                    r_state, w_state_nxt;
  logic [CW-1:0]             r_grant, w_grant_nxt, r_rr, w_rr_nxt, w_sel;
  logic [NCH-1:0][DW:0]      w_head;
  logic [NCH-1:0][AW:0]      w_cnt, w_cnt_nxt;
  logic [NCH-1:0]            w_elig, w_pop, w_gnt_oh;
  logic [DW:0]               w_ghead;
  logic                      w_gvalid, w_hs, w_found, w_release;
  int                        w_idx;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    stream_mux_nch_fifo #(.DW(DW), .AW(AW)) u_fifo (
      .clk        (aclk),
      .rst        (areset),
      .i_wr       (s_tvalid[k]),
      .i_wdata    ({s_tlast[k] & (PACKET_MODE != 0), s_tdata[k*DW +: DW]}),
      .i_rd       (w_pop[k]),
      .i_ovf_clr  (ovf_clr[k]),
      .o_head     (w_head[k]),
      .o_cnt      (w_cnt[k]),
      .o_cnt_nxt  (w_cnt_nxt[k]),
      .o_ovf      (ovf[k]),
      .o_drop_cnt (drop_cnt[k*16 +: 16])
    );
    assign w_elig[k] = (w_cnt[k] != '0) & ~s_arb_req_suppress[k];
  end

  assign w_gnt_oh = NCH'(1) << r_grant;
  assign w_ghead  = w_head[r_grant];
  assign w_gvalid = (r_state == GRANT) && (w_cnt[r_grant] != '0);
  assign w_hs     = w_gvalid & m_tready;
  assign w_pop    = w_hs ? w_gnt_oh : '0;
  assign w_release = w_hs && ((PACKET_MODE == 0) || w_ghead[DW]);

  assign m_tvalid = w_gvalid;
  assign m_tdata  = w_gvalid ? w_ghead[DW-1:0] : '0;
  assign m_tlast  = w_gvalid & w_ghead[DW];
  assign m_tid    = w_gvalid ? r_grant : '0;

  // Round-robin search from rr+1, wrapping, rr itself checked last.
  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 1; i <= NCH; i++) begin
      w_idx = int'(r_rr) + i;
      if (w_idx >= NCH) w_idx = w_idx - NCH;
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_sel   = CW'(w_idx);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_rr_nxt    = r_rr;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_grant_nxt = w_sel;
          w_rr_nxt    = w_sel;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        // Another eligible channel forces a pass through IDLE for fairness.
        if (w_release) begin
          if (|(w_elig & ~w_gnt_oh))            w_state_nxt = IDLE;
          else if (w_cnt_nxt[r_grant] == '0)    w_state_nxt = IDLE;
        end else if (PACKET_MODE == 0 && !w_gvalid) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_rr    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_rr    <= w_rr_nxt;
    end
  end
endmodule

// File: tb/tb_stream_mux_nch.sv
// Directed bench: word-mode instance (AW=4) and packet-mode instance (AW=2) on a shared clock.
module tb_stream_mux_nch;
  localparam int NCH = 4, DW = 9;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic              a_rst, a_m_tvalid, a_m_tready, a_m_tlast;
  logic [NCH-1:0]    a_s_tvalid, a_s_tlast, a_sup, a_ovf, a_ovf_clr;
  logic [NCH*DW-1:0] a_s_tdata;
  logic [DW-1:0]     a_m_tdata;
  logic [1:0]        a_m_tid;
  logic [63:0]       a_drop;

  logic              b_rst, b_m_tvalid, b_m_tready, b_m_tlast;
  logic [NCH-1:0]    b_s_tvalid, b_s_tlast, b_sup, b_ovf, b_ovf_clr;
  logic [NCH*DW-1:0] b_s_tdata;
  logic [DW-1:0]     b_m_tdata;
  logic [1:0]        b_m_tid;
  logic [63:0]       b_drop;

  stream_mux_nch #(.NCH(NCH), .DW(DW), .AW(4), .PACKET_MODE(0)) u_dut_a (
    .aclk(aclk), .areset(a_rst), .s_tvalid(a_s_tvalid), .s_tdata(a_s_tdata), .s_tlast(a_s_tlast),
    .s_arb_req_suppress(a_sup), .m_tvalid(a_m_tvalid), .m_tready(a_m_tready), .m_tdata(a_m_tdata),
    .m_tlast(a_m_tlast), .m_tid(a_m_tid), .ovf(a_ovf), .ovf_clr(a_ovf_clr), .drop_cnt(a_drop)
  );

  stream_mux_nch #(.NCH(NCH), .DW(DW), .AW(2), .PACKET_MODE(1)) u_dut_b (
    .aclk(aclk), .areset(b_rst), .s_tvalid(b_s_tvalid), .s_tdata(b_s_tdata), .s_tlast(b_s_tlast),
    .s_arb_req_suppress(b_sup), .m_tvalid(b_m_tvalid), .m_tready(b_m_tready), .m_tdata(b_m_tdata),
    .m_tlast(b_m_tlast), .m_tid(b_m_tid), .ovf(b_ovf), .ovf_clr(b_ovf_clr), .drop_cnt(b_drop)
  );

  typedef struct {logic [8:0] d; logic [1:0] t; logic l; int c;} rec_t;
  rec_t qa[$], qb[$];
  int n_vec = 0, n_err = 0, cyc = 0, s = 0;
  logic [63:0] exp_drop;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic rec_t at(input rec_t q[$], input int i);
    rec_t r = '{d: '0, t: '0, l: 1'b0, c: -99};
    if (i < q.size()) r = q[i];
    return r;
  endfunction

  task automatic exp_word(input string tag, input rec_t r, input int d, input int t, input int l, input int c);
    chk({tag, "_data"}, 64'(r.d), 64'(d));
    chk({tag, "_tid"},  64'(r.t), 64'(t));
    chk({tag, "_last"}, 64'(r.l), 64'(l));
    chk({tag, "_cyc"},  64'(r.c), 64'(c));
  endtask

  // Record handshakes just before the edge that completes them.
  task automatic tick();
    @(negedge aclk);
    if (a_m_tvalid && a_m_tready) qa.push_back('{d: a_m_tdata, t: a_m_tid, l: a_m_tlast, c: cyc});
    if (b_m_tvalid && b_m_tready) qb.push_back('{d: b_m_tdata, t: b_m_tid, l: b_m_tlast, c: cyc});
    @(posedge aclk);
    #1;
    cyc++;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    a_rst = 1'b1; b_rst = 1'b1;
    a_s_tvalid = '0; a_s_tdata = '0; a_s_tlast = '0; a_sup = '0; a_ovf_clr = '0; a_m_tready = 1'b1;
    b_s_tvalid = '0; b_s_tdata = '0; b_s_tlast = '0; b_sup = '0; b_ovf_clr = '0; b_m_tready = 1'b1;
`ifdef STREAM_MUX_DROP_CNT_EN
    exp_drop = 64'd2;
`else
    exp_drop = 64'd0;
`endif
    ticks(2);
    chk("rst_a_vld",  64'(a_m_tvalid), 64'd0);
    chk("rst_a_data", 64'(a_m_tdata),  64'd0);
    chk("rst_a_tid",  64'(a_m_tid),    64'd0);
    chk("rst_a_ovf",  64'(a_ovf),      64'd0);
    chk("rst_a_drop", a_drop,          64'd0);
    chk("rst_b_vld",  64'(b_m_tvalid), 64'd0);
    chk("rst_b_last", 64'(b_m_tlast),  64'd0);
    a_rst = 1'b0; b_rst = 1'b0;
    ticks(2);

    // One word on every channel at once: rr starts at ch1, one bubble between grants.
    s = cyc;
    a_s_tvalid = 4'hF;
    a_s_tdata  = {9'h013, 9'h012, 9'h011, 9'h010};
    tick();
    a_s_tvalid = '0;
    ticks(12);
    chk("t1_n", 64'(qa.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      exp_word("t1", at(qa, i), (i == 3) ? 'h10 : 'h11 + i, (i + 1) % 4, 0, s + 2 + 2 * i);
    qa.delete();

    // Back-to-back burst on ch2: 2-cycle latency then full rate.
    s = cyc;
    for (int i = 0; i < 8; i++) begin
      a_s_tvalid = 4'b0100;
      a_s_tdata  = '0;
      a_s_tdata[2*DW +: DW] = 9'(i);
      tick();
    end
    a_s_tvalid = '0;
    ticks(6);
    chk("t2_n", 64'(qa.size()), 64'd8);
    for (int i = 0; i < 8; i++) exp_word("t2", at(qa, i), i, 2, 0, s + 2 + i);
    qa.delete();

    // Suppressed ch0 is skipped until released.
    a_sup = 4'b0001;
    a_s_tvalid = 4'b1001;
    a_s_tdata  = {9'h053, 9'h000, 9'h000, 9'h050};
    tick();
    a_s_tvalid = 4'b1000;
    a_s_tdata  = {9'h054, 9'h000, 9'h000, 9'h000};
    tick();
    a_s_tvalid = '0;
    ticks(10);
    chk("t5_n_sup", 64'(qa.size()), 64'd2);
    exp_word("t5_a", at(qa, 0), 'h53, 3, 0, at(qa, 0).c);
    exp_word("t5_b", at(qa, 1), 'h54, 3, 0, at(qa, 0).c + 1);
    qa.delete();
    a_sup = '0;
    ticks(5);
    chk("t5_n_rel", 64'(qa.size()), 64'd1);
    exp_word("t5_c", at(qa, 0), 'h50, 0, 0, at(qa, 0).c);
    qa.delete();

    // Packet mode: ch0 packet with an input gap is not interleaved by ch1.
    s = cyc;
    b_s_tvalid = 4'b0001; b_s_tdata = '0; b_s_tdata[0 +: DW] = 9'h0A0; tick();
    b_s_tvalid = 4'b0011; b_s_tdata[0 +: DW] = 9'h0A1; b_s_tdata[DW +: DW] = 9'h0B0; tick();
    b_s_tvalid = 4'b0010; b_s_tdata[DW +: DW] = 9'h0B1; tick();
    b_s_tvalid = 4'b0010; b_s_tdata[DW +: DW] = 9'h0B2; b_s_tlast = 4'b0010; tick();
    b_s_tvalid = 4'b0001; b_s_tdata[0 +: DW] = 9'h0A2; b_s_tlast = 4'b0001; tick();
    b_s_tvalid = '0; b_s_tlast = '0;
    ticks(10);
    chk("t3_n", 64'(qb.size()), 64'd6);
    exp_word("t3_0", at(qb, 0), 'h0A0, 0, 0, s + 2);
    exp_word("t3_1", at(qb, 1), 'h0A1, 0, 0, s + 3);
    exp_word("t3_2", at(qb, 2), 'h0A2, 0, 1, s + 5);
    exp_word("t3_3", at(qb, 3), 'h0B0, 1, 0, s + 7);
    exp_word("t3_4", at(qb, 4), 'h0B1, 1, 0, s + 8);
    exp_word("t3_5", at(qb, 5), 'h0B2, 1, 1, s + 9);
    qb.delete();

    // Overflow on a depth-4 FIFO with the output stalled.
    b_m_tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      b_s_tvalid = 4'b0010;
      b_s_tdata  = '0;
      b_s_tdata[DW +: DW] = 9'(9'h040 + i);
      b_s_tlast  = (i == 3) ? 4'b0010 : 4'b0000;
      tick();
    end
    b_s_tvalid = '0; b_s_tlast = '0;
    ticks(2);
    chk("t4_ovf",   64'(b_ovf),      64'h2);
    chk("t4_drop",  64'(b_drop[31:16]), exp_drop);
    chk("t4_drop0", 64'(b_drop[15:0]),  64'd0);
    chk("t4_vld",   64'(b_m_tvalid), 64'd1);
    chk("t4_hold",  64'(b_m_tdata),  64'h040);
    chk("t4_tid",   64'(b_m_tid),    64'd1);
    b_ovf_clr = 4'b0010;
    tick();
    b_ovf_clr = '0;
    chk("t4_ovf_clr",  64'(b_ovf), 64'd0);
    chk("t4_drop_clr", b_drop,     64'd0);
    s = cyc;
    b_m_tready = 1'b1;
    ticks(8);
    chk("t4_n", 64'(qb.size()), 64'd4);
    for (int i = 0; i < 4; i++) exp_word("t4_w", at(qb, i), 'h40 + i, 1, (i == 3) ? 1 : 0, s + i);
    qb.delete();

    // Asynchronous reset mid-packet with output stalled.
    b_m_tready = 1'b0;
    b_s_tvalid = 4'b0100; b_s_tdata = '0; b_s_tdata[2*DW +: DW] = 9'h060; tick();
    b_s_tdata[2*DW +: DW] = 9'h061; tick();
    b_s_tvalid = '0;
    ticks(3);
    chk("t6_pre_vld",  64'(b_m_tvalid), 64'd1);
    chk("t6_pre_data", 64'(b_m_tdata),  64'h060);
    b_rst = 1'b1;
    #1;
    chk("t6_rst_vld",  64'(b_m_tvalid), 64'd0);
    chk("t6_rst_data", 64'(b_m_tdata),  64'd0);
    chk("t6_rst_tid",  64'(b_m_tid),    64'd0);
    ticks(2);
    b_rst = 1'b0;
    b_m_tready = 1'b1;
    qb.delete();
    ticks(8);
    chk("t6_stale_n", 64'(qb.size()), 64'd0);
    s = cyc;
    b_s_tvalid = 4'b1000; b_s_tdata = '0; b_s_tdata[3*DW +: DW] = 9'h077; b_s_tlast = 4'b1000;
    tick();
    b_s_tvalid = '0; b_s_tlast = '0;
    ticks(6);
    chk("t6_post_n", 64'(qb.size()), 64'd1);
    exp_word("t6_post", at(qb, 0), 'h77, 3, 1, s + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
